// File: rtl/reg_file_rename_pkg.sv
// reg_file_rename_pkg: widths and constants shared by the register file, ROB and dispatcher
package reg_file_rename_pkg;
    localparam int REG_NUM  = 32;
    localparam int REG_ID_W = 5;
    localparam int ROB_ID_W = 4;
    localparam int DATA_W   = 32;
    localparam logic [REG_ID_W-1:0] ZERO_REG = '0;
endpackage

// File: rtl/reg_file_rename_rf_read_port.sv
// rf_read_port: operand select for one read port, with same-cycle commit bypass
module rf_read_port
    import reg_file_rename_pkg::*;
(
    input  logic [REG_ID_W-1:0] rs_id_i,
    input  logic [DATA_W-1:0]   ent_val_i,
    input  logic                ent_busy_i,
    input  logic [ROB_ID_W-1:0] ent_tag_i,
    input  logic                commit_vld_i,
    input  logic [REG_ID_W-1:0] commit_reg_id_i,
    input  logic [ROB_ID_W-1:0] commit_rob_id_i,
    input  logic [DATA_W-1:0]   commit_val_i,
    output logic [DATA_W-1:0]   rs_val_o,
    output logic                rs_busy_o,
    output logic [ROB_ID_W-1:0] rs_tag_o
);
    logic is_zero;
    logic hit;
    // only the commit of the current producer may forward; older producers are stale
    always_comb begin
        is_zero   = rs_id_i == ZERO_REG;
        hit       = ent_busy_i && commit_vld_i && commit_reg_id_i == rs_id_i && commit_rob_id_i == ent_tag_i;
        rs_val_o  = is_zero ? '0 : hit ? commit_val_i : ent_val_i;
        rs_busy_o = is_zero ? 1'b0 : hit ? 1'b0 : ent_busy_i;
        rs_tag_o  = is_zero ? '0 : ent_tag_i;
    end
endmodule

// File: rtl/reg_file_rename.sv
// reg_file_rename: architectural register file with per-register rename tags
// written by ROB commit, renamed by dispatch, flushed by ROB clear.
module reg_file_rename
    import reg_file_rename_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                clear,
    input  logic                rename_en,
    input  logic [REG_ID_W-1:0] rename_rd,
    input  logic [ROB_ID_W-1:0] rename_rob_id,
    input  logic                commit_en,
    input  logic [REG_ID_W-1:0] commit_reg_id,
    input  logic [ROB_ID_W-1:0] commit_rob_id,
    input  logic [DATA_W-1:0]   commit_val,
    input  logic [REG_ID_W-1:0] rs1_id,
    input  logic [REG_ID_W-1:0] rs2_id,
    output logic [DATA_W-1:0]   rs1_val,
    output logic [DATA_W-1:0]   rs2_val,
    output logic                rs1_busy,
    output logic                rs2_busy,
    output logic [ROB_ID_W-1:0] rs1_tag,
    output logic [ROB_ID_W-1:0] rs2_tag
);
    logic [DATA_W-1:0]   val_q  [REG_NUM];
    logic [DATA_W-1:0]   val_d  [REG_NUM];
    logic                busy_q [REG_NUM];
    logic                busy_d [REG_NUM];
    logic [ROB_ID_W-1:0] tag_q  [REG_NUM];
    logic [ROB_ID_W-1:0] tag_d  [REG_NUM];
    logic                commit_vld;

    assign commit_vld = rdy && commit_en;

    // rename is applied after commit so it wins busy/tag on the same register
    always_comb begin
        val_d  = val_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        if (commit_vld && commit_reg_id != ZERO_REG) begin
            val_d[commit_reg_id] = commit_val;
            if (busy_q[commit_reg_id] && tag_q[commit_reg_id] == commit_rob_id)
                busy_d[commit_reg_id] = 1'b0;
        end
        if (rdy && clear) begin
            for (int i = 0; i < REG_NUM; i++) busy_d[i] = 1'b0;
        end else if (rdy && rename_en && rename_rd != ZERO_REG) begin
            busy_d[rename_rd] = 1'b1;
            tag_d[rename_rd]  = rename_rob_id;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                val_q[i]  <= '0;
                busy_q[i] <= 1'b0;
                tag_q[i]  <= '0;
            end
        end else begin
            val_q  <= val_d;
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

    rf_read_port u_rs1 (
        .rs_id_i         (rs1_id),
        .ent_val_i       (val_q[rs1_id]),
        .ent_busy_i      (busy_q[rs1_id]),
        .ent_tag_i       (tag_q[rs1_id]),
        .commit_vld_i    (commit_vld),
        .commit_reg_id_i (commit_reg_id),
        .commit_rob_id_i (commit_rob_id),
        .commit_val_i    (commit_val),
        .rs_val_o        (rs1_val),
        .rs_busy_o       (rs1_busy),
        .rs_tag_o        (rs1_tag)
    );

    rf_read_port u_rs2 (
        .rs_id_i         (rs2_id),
        .ent_val_i       (val_q[rs2_id]),
        .ent_busy_i      (busy_q[rs2_id]),
        .ent_tag_i       (tag_q[rs2_id]),
        .commit_vld_i    (commit_vld),
        .commit_reg_id_i (commit_reg_id),
        .commit_rob_id_i (commit_rob_id),
        .commit_val_i    (commit_val),
        .rs_val_o        (rs2_val),
        .rs_busy_o       (rs2_busy),
        .rs_tag_o        (rs2_tag)
    );
endmodule

// File: tb/tb_reg_file_rename.sv
// tb_reg_file_rename: scoreboard bench for reg_file_rename
module tb_reg_file_rename;
    logic        clk = 1'b0;
    logic        rst, rdy, clear, rename_en, commit_en;
    logic [4:0]  rename_rd, commit_reg_id, rs1_id, rs2_id;
    logic [3:0]  rename_rob_id, commit_rob_id;
    logic [31:0] commit_val;
    logic [31:0] rs1_val, rs2_val;
    logic        rs1_busy, rs2_busy;
    logic [3:0]  rs1_tag, rs2_tag;

    typedef struct {
        string       nm;
        bit          port;
        logic [31:0] val;
        logic        busy;
        logic [3:0]  tag;
        bit          ct;
        logic [31:0] got_v;
        logic        got_b;
        logic [3:0]  got_t;
    } exp_t;

    exp_t pend[$];
    exp_t done[$];
    int   n_run = 0;
    int   n_fail = 0;

    reg_file_rename dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .rename_en(rename_en), .rename_rd(rename_rd), .rename_rob_id(rename_rob_id),
        .commit_en(commit_en), .commit_reg_id(commit_reg_id), .commit_rob_id(commit_rob_id),
        .commit_val(commit_val), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rs1_tag(rs1_tag), .rs2_tag(rs2_tag)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clear = 0; rename_en = 0; commit_en = 0;
        rename_rd = 0; rename_rob_id = 0; commit_reg_id = 0; commit_rob_id = 0; commit_val = 0;
    endtask

    task automatic rename(input logic [4:0] rd, input logic [3:0] id);
        rename_en = 1; rename_rd = rd; rename_rob_id = id;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [3:0] id, input logic [31:0] v);
        commit_en = 1; commit_reg_id = rd; commit_rob_id = id; commit_val = v;
    endtask

    task automatic push(input string nm, input bit port, input logic [31:0] v,
                        input logic b, input logic [3:0] t, input bit ct);
        exp_t e;
        e.nm = nm; e.port = port; e.val = v; e.busy = b; e.tag = t; e.ct = ct;
        e.got_v = 'x; e.got_b = 'x; e.got_t = 'x;
        pend.push_back(e);
    endtask

    // capture DUT outputs for every pending expectation, mid-cycle
    task automatic snap();
        exp_t e;
        #1;
        while (pend.size() > 0) begin
            e = pend.pop_front();
            e.got_v = e.port ? rs2_val : rs1_val;
            e.got_b = e.port ? rs2_busy : rs1_busy;
            e.got_t = e.port ? rs2_tag : rs1_tag;
            done.push_back(e);
        end
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 0; rdy = 1; idle(); rs1_id = 0; rs2_id = 0;
        tick(); tick();
        rst = 1;
        rs1_id = 5; rs2_id = 31;
        push("rst_x5", 0, 0, 0, 0, 1);
        push("rst_x31", 1, 0, 0, 0, 1);
        snap();
        commit(5, 3, 32'hDEAD);
        push("x5_idle_commit_same_cycle", 0, 0, 0, 0, 1);
        snap();
        tick(); idle();
        push("x5_commit_next", 0, 32'hDEAD, 0, 0, 0);
        snap();
        while (done.size() > 0) begin
            e = done.pop_front(); n_run++;
            if (e.got_v !== e.val || e.got_b !== e.busy || (e.ct && e.got_t !== e.tag)) begin
                n_fail++;
                $display("FAIL %s: got val=%h busy=%b tag=%0d, expected val=%h busy=%b tag=%0d", e.nm, e.got_v, e.got_b, e.got_t, e.val, e.busy, e.tag);
            end
        end
    endtask

    task automatic test_bypass();
        exp_t e;
        rename(7, 2); tick(); idle();
        rs1_id = 7;
        push("x7_pending", 0, 0, 1, 2, 1);
        snap();
        commit(7, 2, 32'h1234);
        push("x7_bypass", 0, 32'h1234, 0, 0, 0);
        snap();
        tick(); idle();
        push("x7_stored", 0, 32'h1234, 0, 0, 0);
        snap();
        while (done.size() > 0) begin
            e = done.pop_front(); n_run++;
            if (e.got_v !== e.val || e.got_b !== e.busy || (e.ct && e.got_t !== e.tag)) begin
                n_fail++;
                $display("FAIL %s: got val=%h busy=%b tag=%0d, expected val=%h busy=%b tag=%0d", e.nm, e.got_v, e.got_b, e.got_t, e.val, e.busy, e.tag);
            end
        end
    endtask

    task automatic test_younger_rename();
        exp_t e;
        rename(7, 2); tick();
        rename(7, 5); tick(); idle();
        commit(7, 2, 32'h11);
        rs1_id = 7;
        push("x7_stale_no_bypass", 0, 32'h1234, 1, 5, 1);
        snap();
        tick(); idle();
        push("x7_stale_commit", 0, 32'h11, 1, 5, 1);
        snap();
        commit(7, 5, 32'h22);
        tick(); idle();
        push("x7_final_commit", 0, 32'h22, 0, 0, 0);
        snap();
        while (done.size() > 0) begin
            e = done.pop_front(); n_run++;
            if (e.got_v !== e.val || e.got_b !== e.busy || (e.ct && e.got_t !== e.tag)) begin
                n_fail++;
                $display("FAIL %s: got val=%h busy=%b tag=%0d, expected val=%h busy=%b tag=%0d", e.nm, e.got_v, e.got_b, e.got_t, e.val, e.busy, e.tag);
            end
        end
    endtask

    task automatic test_same_cycle();
        exp_t e;
        rename(9, 4); tick(); idle();
        rename(9, 6); commit(9, 4, 32'h99);
        rs2_id = 9;
        push("x9_bypass_hides_rename", 1, 32'h99, 0, 0, 0);
        snap();
        tick(); idle();
        push("x9_rename_wins", 1, 32'h99, 1, 6, 1);
        snap();
        while (done.size() > 0) begin
            e = done.pop_front(); n_run++;
            if (e.got_v !== e.val || e.got_b !== e.busy || (e.ct && e.got_t !== e.tag)) begin
                n_fail++;
                $display("FAIL %s: got val=%h busy=%b tag=%0d, expected val=%h busy=%b tag=%0d", e.nm, e.got_v, e.got_b, e.got_t, e.val, e.busy, e.tag);
            end
        end
    endtask

    task automatic test_clear();
        exp_t e;
        commit(3, 0, 32'h33); tick(); idle();
        rename(3, 1); tick();
        rename(4, 2); tick();
        rename(8, 3); tick(); idle();
        rs1_id = 3; rs2_id = 8;
        push("x3_pre_clear", 0, 32'h33, 1, 1, 1);
        push("x8_pre_clear", 1, 0, 1, 3, 1);
        snap();
        clear = 1; rename(10, 4);
        tick(); idle();
        rs1_id = 3; rs2_id = 4;
        push("x3_cleared", 0, 32'h33, 0, 0, 0);
        push("x4_cleared", 1, 0, 0, 0, 0);
        snap();
        rs1_id = 8; rs2_id = 10;
        push("x8_cleared", 0, 0, 0, 0, 0);
        push("x10_rename_dropped", 1, 0, 0, 0, 0);
        snap();
        while (done.size() > 0) begin
            e = done.pop_front(); n_run++;
            if (e.got_v !== e.val || e.got_b !== e.busy || (e.ct && e.got_t !== e.tag)) begin
                n_fail++;
                $display("FAIL %s: got val=%h busy=%b tag=%0d, expected val=%h busy=%b tag=%0d", e.nm, e.got_v, e.got_b, e.got_t, e.val, e.busy, e.tag);
            end
        end
    endtask

    task automatic test_x0_rdy();
        exp_t e;
        rename(0, 1); commit(0, 1, 32'hFFFF);
        rs1_id = 0;
        push("x0_same_cycle", 0, 0, 0, 0, 1);
        snap();
        tick(); idle();
        push("x0_after", 0, 0, 0, 0, 1);
        snap();
        rename(9, 6); tick(); idle();
        rdy = 0;
        rename(6, 7); commit(6, 7, 32'h66);
        tick(); idle();
        commit(9, 6, 32'hAB);
        rs1_id = 6; rs2_id = 9;
        push("x6_hold_rdy0", 0, 0, 0, 0, 0);
        push("x9_no_bypass_rdy0", 1, 32'h99, 1, 6, 1);
        snap();
        tick(); idle(); rdy = 1;
        push("x6_hold_after", 0, 0, 0, 0, 0);
        push("x9_hold_after", 1, 32'h99, 1, 6, 1);
        snap();
        while (done.size() > 0) begin
            e = done.pop_front(); n_run++;
            if (e.got_v !== e.val || e.got_b !== e.busy || (e.ct && e.got_t !== e.tag)) begin
                n_fail++;
                $display("FAIL %s: got val=%h busy=%b tag=%0d, expected val=%h busy=%b tag=%0d", e.nm, e.got_v, e.got_b, e.got_t, e.val, e.busy, e.tag);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        rst = 0; rdy = 0;
        rename(12, 3); commit(5, 1, 32'h5555);
        tick(); idle();
        rst = 1; rdy = 1;
        rs1_id = 5; rs2_id = 9;
        push("x5_mid_reset", 0, 0, 0, 0, 1);
        push("x9_mid_reset", 1, 0, 0, 0, 1);
        snap();
        rs1_id = 12; rs2_id = 7;
        push("x12_mid_reset", 0, 0, 0, 0, 1);
        push("x7_mid_reset", 1, 0, 0, 0, 1);
        snap();
        while (done.size() > 0) begin
            e = done.pop_front(); n_run++;
            if (e.got_v !== e.val || e.got_b !== e.busy || (e.ct && e.got_t !== e.tag)) begin
                n_fail++;
                $display("FAIL %s: got val=%h busy=%b tag=%0d, expected val=%h busy=%b tag=%0d", e.nm, e.got_v, e.got_b, e.got_t, e.val, e.busy, e.tag);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_younger_rename();
        test_same_cycle();
        test_clear();
        test_x0_rdy();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_file_rename.md
Name: reg_file_rename

Overview:
- Architectural register file with per-register rename tags. It is the write-back end of the reorder buffer's commit port.
- The dispatcher renames rd to a ROB id at issue. It reads rs1/rs2 as either a ready value or a pending ROB tag.
- The ROB commit writes the value and releases the tag. The ROB clear flushes all pending tags on mispredict or JALR redirect.

Parameters:
REG_NUM, 32, number of architectural registers (x0 hardwired zero)
REG_ID_W, 5, register index width
ROB_ID_W, 4, ROB tag width (16 entries)
DATA_W, 32, register data width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-low (rst==0 resets on clk edge)
rdy  in  1  global ready; when 0, all state holds
clear  in  1  ROB flush; drops every pending tag
rename_en  in  1  dispatcher issues an instruction writing rd
rename_rd  in  REG_ID_W  destination register of issued instruction
rename_rob_id  in  ROB_ID_W  ROB entry allocated to it
commit_en  in  1  ROB commits an entry that writes a register
commit_reg_id  in  REG_ID_W  destination register of committed entry
commit_rob_id  in  ROB_ID_W  ROB id of committed entry
commit_val  in  DATA_W  committed result
rs1_id, rs2_id  in  REG_ID_W  operand read indices (combinational)
rs1_val, rs2_val  out  DATA_W  operand value (valid when busy==0)
rs1_busy, rs2_busy  out  1  operand still pending
rs1_tag, rs2_tag  out  ROB_ID_W  pending producer ROB id (valid when busy==1)

Behaviour:
- State: val[REG_NUM], busy[REG_NUM], tag[REG_NUM].
- Reset (rst==0 at edge): all val=0, busy=0, tag=0. Takes priority over rdy and all other inputs. Read outputs follow from the reset state: val 0, busy 0, tag 0.
- rdy==0: no state change. Read ports stay combinational.
- Commit (commit_en && commit_reg_id!=0):
  - val[commit_reg_id] <= commit_val always.
  - busy cleared only if busy[commit_reg_id] && tag[commit_reg_id]==commit_rob_id.
  - On a tag mismatch (a younger rename exists), busy and tag are kept.
- Rename (rename_en && rename_rd!=0 && !clear): busy[rename_rd] <= 1, tag[rename_rd] <= rename_rob_id.
- Rename and commit to the same register in the same cycle: the rename sets busy/tag and wins. The commit still writes val.
- Clear: all busy <= 0 next edge. Any commit in the same cycle still writes val. Rename in the same cycle is ignored.
- x0: never written, never busy; reads return val 0, busy 0, tag 0.
- Read ports (combinational, per port, rsN_id = r):
  - r==0 -> val 0, busy 0.
  - else if busy[r] && commit_en && commit_reg_id==r && commit_rob_id==tag[r] -> val=commit_val, busy=0 (same-cycle bypass).
  - else -> val[r], busy[r], tag[r].
  - A same-cycle rename is NOT visible on the read ports, so an instruction with rd==rs reads the old mapping.
  - The bypass is gated by rdy and clear: if rdy==0, no bypass. During clear, a bypass still applies; otherwise stored busy is reported.
- Latency: writes are visible on the next cycle. The commit value is visible the same cycle via the bypass.

Decomposition:
- Shared macros header: REG_ID_W, ROB_ID_W, DATA_W widths, zero-register constant. These are shared with the ROB and dispatcher.
- One sub-module, rf_read_port: bypass/select logic, instantiated twice (rs1, rs2).

Test Plan:
- Reset, then read x5 -> val 0, busy 0. Commit x5 tag3 val 0xDEAD with x5 not busy -> next cycle val 0xDEAD, busy 0.
- Rename x7->tag 2. Next cycle read x7 -> busy 1, tag 2. Commit (x7, 2, 0x1234) that cycle -> read gives val 0x1234, busy 0 combinationally. Next cycle stored busy is 0.
- Rename x7->2, then rename x7->5. Commit (x7, 2, 0x11) -> val 0x11, busy 1, tag 5. Commit (x7, 5, 0x22) -> busy 0, val 0x22.
- Same cycle: rename x9->6 and commit (x9, 4, 0x99) with tag[x9]=4 -> next cycle val 0x99, busy 1, tag 6.
- Rename x3, x4, x8 to tags 1, 2, 3, then assert clear together with rename x10->4 -> all busy 0, x10 not busy, values unchanged.
- Rename x0->1 and commit (x0, 1, 0xFFFF) -> x0 reads 0, busy 0. With rdy=0, rename/commit on x6 -> no change. Drive rst=0 mid-stream -> next cycle all registers 0, not busy.
